// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among NUM_REQ packet sources.
// A grant lasts until req_last or MAX_BURST beats; every release costs one IDLE cycle.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 8,
   parameter int ID_WIDTH   = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_wr_valid,
   output logic [DATA_WIDTH-1:0]         fifo_wr_data,
   output logic [ID_WIDTH-1:0]           grant_id,
   output logic                          busy
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

   state_e              state_q, state_d;
   logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
   logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;

   logic                  pick_vld;
   logic [ID_WIDTH-1:0]   pick_id;
   logic                  g_valid, g_last;
   logic [DATA_WIDTH-1:0] g_data;
   logic                  xfer, release_now;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      g_valid = 1'b0;
      g_last  = 1'b0;
      g_data  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_id_q == ID_WIDTH'(k)) begin
            g_valid = req_valid[k];
            g_last  = req_last[k];
            g_data  = req_data[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Search order rr_ptr+1 .. NUM_REQ-1 first, then wrap to 0 .. rr_ptr.
   always_comb begin
      pick_vld = 1'b0;
      pick_id  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!pick_vld && req_valid[k] && (ID_WIDTH'(k) > rr_ptr_q)) begin
            pick_vld = 1'b1;
            pick_id  = ID_WIDTH'(k);
         end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!pick_vld && req_valid[k] && (ID_WIDTH'(k) <= rr_ptr_q)) begin
            pick_vld = 1'b1;
            pick_id  = ID_WIDTH'(k);
         end
      end
   end

   assign busy          = (state_q == GRANT);
   assign xfer          = busy && g_valid && !fifo_full;
   assign release_now   = xfer && (g_last || (beat_cnt_q == CNT_W'(MAX_BURST - 1)));
   assign fifo_wr_valid = busy && g_valid;
   assign fifo_wr_data  = busy ? g_data : '0;
   assign grant_id      = grant_id_q;

   always_comb begin
      req_ready = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         req_ready[k] = xfer && (grant_id_q == ID_WIDTH'(k));
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d    = GRANT;
               grant_id_d = pick_id;
               beat_cnt_d = '0;
            end
         end
         GRANT: begin
            if (xfer) begin
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
               if (release_now) begin
                  rr_ptr_d = grant_id_q;
                  state_d  = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      if (rst) begin
         state_q    <= IDLE;
         grant_id_q <= '0;
         rr_ptr_q   <= ID_WIDTH'(NUM_REQ - 1);
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: requester queues drive traffic; a packet-level model predicts
// every cycle's outputs and the sequence of beats the FIFO should receive.
module tb_fifo_wr_arbiter;

   localparam int NUM_REQ    = 4;
   localparam int DATA_WIDTH = 8;
   localparam int MAX_BURST  = 8;
   localparam int ID_WIDTH   = 2;

   logic                          clk = 1'b0;
   logic                          rst;
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_full;
   logic                          fifo_wr_valid;
   logic [DATA_WIDTH-1:0]         fifo_wr_data;
   logic [ID_WIDTH-1:0]           grant_id;
   logic                          busy;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST), .ID_WIDTH(ID_WIDTH)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
      .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_valid(fifo_wr_valid),
      .fifo_wr_data(fifo_wr_data), .grant_id(grant_id), .busy(busy)
   );

   logic [15:0] obs;
   assign obs = {req_ready, fifo_wr_valid, fifo_wr_data, grant_id, busy};

   // Each pending beat is {last, data}; the head of queue i is what requester i presents.
   logic [8:0]         src_q [NUM_REQ][$];
   logic [NUM_REQ-1:0] gap;
   int dut_wr[$], dut_wr_cyc[$], exp_wr[$], dut_gnt[$], dut_gnt_cyc[$];
   int cyc, n_checks, n_fail;
   int m_owner, m_gid, m_ptr, m_beats;
   logic busy_prev;

   always @(negedge clk) begin
      if (!rst && fifo_wr_valid && !fifo_full) begin
         dut_wr.push_back(int'(grant_id) * 256 + int'(fifo_wr_data));
         dut_wr_cyc.push_back(cyc);
      end
      if (busy === 1'b1 && !busy_prev) begin
         dut_gnt.push_back(int'(grant_id));
         dut_gnt_cyc.push_back(cyc);
      end
      busy_prev = (busy === 1'b1);
   end

   // Owner is -1 when nobody holds the port; a packet ends on last or after MAX_BURST beats.
   function automatic logic [15:0] exp_out();
      logic [3:0] r;
      logic       v;
      logic [7:0] d;
      if (m_owner < 0) return {4'b0, 1'b0, 8'h00, m_gid[1:0], 1'b0};
      v = req_valid[m_owner];
      d = req_data[m_owner*DATA_WIDTH +: DATA_WIDTH];
      r = (v && !fifo_full) ? 4'(1 << m_owner) : 4'b0;
      return {r, v, d, m_owner[1:0], 1'b1};
   endfunction

   task automatic model_step();
      if (rst) begin
         m_owner = -1;
         m_gid   = 0;
         m_ptr   = NUM_REQ - 1;
         m_beats = 0;
      end else if (m_owner < 0) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            int idx = (m_ptr + k) % NUM_REQ;
            if (m_owner < 0 && req_valid[idx]) begin
               m_owner = idx;
               m_gid   = idx;
               m_beats = 0;
            end
         end
      end else if (req_valid[m_owner] && !fifo_full) begin
         exp_wr.push_back(m_owner * 256 + int'(req_data[m_owner*DATA_WIDTH +: DATA_WIDTH]));
         m_beats++;
         if (req_last[m_owner] || m_beats == MAX_BURST) begin
            m_ptr   = m_owner;
            m_owner = -1;
         end
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NUM_REQ; i++) begin
         logic [8:0] b;
         if (src_q[i].size() != 0 && !gap[i]) begin
            b = src_q[i][0];
            req_valid[i] = 1'b1;
            req_last[i]  = b[8];
            req_data[i*DATA_WIDTH +: DATA_WIDTH] = b[7:0];
         end else begin
            req_valid[i] = 1'b0;
            req_last[i]  = 1'b0;
            req_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
         end
      end
   endtask

   task automatic advance();
      logic [NUM_REQ-1:0] rdy;
      rdy = req_ready;
      @(posedge clk);
      model_step();
      for (int i = 0; i < NUM_REQ; i++)
         if (rdy[i] === 1'b1 && src_q[i].size() != 0) void'(src_q[i].pop_front());
      cyc++;
      #1;
   endtask

   task automatic clear_all();
      for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
      dut_wr.delete(); dut_wr_cyc.delete(); exp_wr.delete(); dut_gnt.delete(); dut_gnt_cyc.delete();
   endtask

   task automatic test_reset();
      for (int k = 0; k < 4; k++) begin
         rst = (k < 3); fifo_full = 1'($urandom_range(0, 1)); gap = '0;
         drive();
         if (k < 3) begin
            req_valid = 4'($urandom);
            req_data  = 32'($urandom);
         end
         @(negedge clk);
         n_checks++;
         if (obs !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_outputs cyc=%0d got=%h required=%h", cyc, obs, 16'h0000);
         end
         advance();
      end
   endtask

   task automatic test_single();
      int c0, got;
      clear_all();
      c0 = cyc;
      src_q[2].push_back({1'b0, 8'hA1});
      src_q[2].push_back({1'b0, 8'hA2});
      src_q[2].push_back({1'b1, 8'hA3});
      for (int k = 0; k < 7; k++) begin
         rst = 1'b0; fifo_full = 1'b0; gap = '0;
         drive();
         @(negedge clk);
         n_checks++;
         if (obs !== exp_out()) begin
            n_fail++;
            $display("FAIL single_cycle cyc=%0d got=%h required=%h", cyc, obs, exp_out());
         end
         advance();
      end
      got = (dut_gnt.size() > 0) ? dut_gnt[0] : -1;
      n_checks++;
      if (got !== 2) begin n_fail++; $display("FAIL single_grant_id got=%0d required=2", got); end
      got = (dut_gnt.size() > 0) ? dut_gnt_cyc[0] - c0 : -1;
      n_checks++;
      if (got !== 1) begin n_fail++; $display("FAIL single_grant_latency got=%0d required=1", got); end
      n_checks++;
      if (dut_wr.size() !== 3) begin
         n_fail++; $display("FAIL single_beat_count got=%0d required=3", dut_wr.size());
      end
      for (int j = 0; j < 3; j++) begin
         got = (j < dut_wr.size()) ? dut_wr[j] : -1;
         n_checks++;
         if (got !== 2 * 256 + 'hA1 + j) begin
            n_fail++; $display("FAIL single_data[%0d] got=%h required=%h", j, got, 2 * 256 + 'hA1 + j);
         end
         got = (j < dut_wr.size()) ? dut_wr_cyc[j] - c0 : -1;
         n_checks++;
         if (got !== j + 1) begin
            n_fail++; $display("FAIL single_beat_cycle[%0d] got=%0d required=%0d", j, got, j + 1);
         end
      end
   endtask

   task automatic test_round_robin();
      int order [6] = '{0, 1, 3, 0, 1, 3};
      int got;
      for (int k = 0; k < 16; k++) begin
         rst = (k == 0); fifo_full = 1'b0; gap = '0;
         if (k == 0) clear_all();
         if (k == 1) begin
            dut_gnt.delete(); dut_gnt_cyc.delete();
            for (int n = 0; n < 2; n++) begin
               src_q[0].push_back({1'b1, 8'(8'h00 + n)});
               src_q[1].push_back({1'b1, 8'(8'h10 + n)});
               src_q[3].push_back({1'b1, 8'(8'h30 + n)});
            end
         end
         drive();
         @(negedge clk);
         n_checks++;
         if (obs !== exp_out()) begin
            n_fail++;
            $display("FAIL rr_cycle cyc=%0d got=%h required=%h", cyc, obs, exp_out());
         end
         advance();
      end
      n_checks++;
      if (dut_gnt.size() !== 6) begin
         n_fail++; $display("FAIL rr_grant_count got=%0d required=6", dut_gnt.size());
      end
      for (int j = 0; j < 6; j++) begin
         got = (j < dut_gnt.size()) ? dut_gnt[j] : -1;
         n_checks++;
         if (got !== order[j]) begin
            n_fail++; $display("FAIL rr_order[%0d] got=%0d required=%0d", j, got, order[j]);
         end
         if (j > 0) begin
            got = (j < dut_gnt.size()) ? dut_gnt_cyc[j] - dut_gnt_cyc[j-1] : -1;
            n_checks++;
            if (got !== 2) begin
               n_fail++; $display("FAIL rr_spacing[%0d] got=%0d required=2", j, got);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int got;
      for (int k = 0; k < 11; k++) begin
         rst = (k == 0); gap = '0;
         fifo_full = (k >= 3 && k <= 5);
         if (k == 0) clear_all();
         if (k == 1) begin
            for (int n = 0; n < 4; n++) src_q[1].push_back({1'(n == 3), 8'(8'h10 + n)});
         end
         drive();
         @(negedge clk);
         n_checks++;
         if (obs !== exp_out()) begin
            n_fail++;
            $display("FAIL bp_cycle cyc=%0d got=%h required=%h", cyc, obs, exp_out());
         end
         if (fifo_full) begin
            n_checks++;
            if (req_ready !== 4'b0000) begin
               n_fail++; $display("FAIL bp_ready_while_full cyc=%0d got=%b required=0000", cyc, req_ready);
            end
         end
         advance();
      end
      n_checks++;
      if (dut_wr.size() !== 4) begin
         n_fail++; $display("FAIL bp_beat_count got=%0d required=4", dut_wr.size());
      end
      for (int j = 0; j < 4; j++) begin
         got = (j < dut_wr.size()) ? dut_wr[j] : -1;
         n_checks++;
         if (got !== 256 + 'h10 + j) begin
            n_fail++; $display("FAIL bp_data[%0d] got=%h required=%h", j, got, 256 + 'h10 + j);
         end
      end
   endtask

   task automatic test_max_burst();
      int got, want;
      for (int k = 0; k < 16; k++) begin
         rst = (k == 0); fifo_full = 1'b0; gap = '0;
         if (k == 0) clear_all();
         if (k == 1) begin
            for (int n = 0; n < 20; n++) src_q[0].push_back({1'b0, 8'(8'h40 + n)});
            src_q[3].push_back({1'b1, 8'hF0});
         end
         drive();
         @(negedge clk);
         n_checks++;
         if (obs !== exp_out()) begin
            n_fail++;
            $display("FAIL burst_cycle cyc=%0d got=%h required=%h", cyc, obs, exp_out());
         end
         advance();
      end
      for (int j = 0; j < 10; j++) begin
         want = (j < 8) ? 'h40 + j : (j == 8) ? 3 * 256 + 'hF0 : 'h48;
         got  = (j < dut_wr.size()) ? dut_wr[j] : -1;
         n_checks++;
         if (got !== want) begin
            n_fail++; $display("FAIL burst_seq[%0d] got=%h required=%h", j, got, want);
         end
      end
   endtask

   task automatic test_reset_mid();
      int got;
      for (int k = 0; k < 14; k++) begin
         rst = (k == 0 || k == 3); fifo_full = 1'b0; gap = '0;
         if (k == 0) clear_all();
         if (k == 1) begin
            for (int n = 0; n < 5; n++) src_q[1].push_back({1'(n == 4), 8'(8'h20 + n)});
         end
         if (k == 4) begin
            src_q[0].push_back({1'b1, 8'h30});
            dut_gnt.delete(); dut_gnt_cyc.delete();
         end
         drive();
         @(negedge clk);
         n_checks++;
         if (obs !== exp_out()) begin
            n_fail++;
            $display("FAIL rstmid_cycle cyc=%0d got=%h required=%h", cyc, obs, exp_out());
         end
         if (k == 4) begin
            n_checks++;
            if (obs !== 16'h0000) begin
               n_fail++; $display("FAIL rstmid_idle_outputs got=%h required=%h", obs, 16'h0000);
            end
         end
         advance();
      end
      got = (dut_gnt.size() > 0) ? dut_gnt[0] : -1;
      n_checks++;
      if (got !== 0) begin n_fail++; $display("FAIL rstmid_first_grant got=%0d required=0", got); end
      got = (dut_gnt.size() > 1) ? dut_gnt[1] : -1;
      n_checks++;
      if (got !== 1) begin n_fail++; $display("FAIL rstmid_second_grant got=%0d required=1", got); end
   endtask

   task automatic test_valid_gap();
      int got;
      for (int k = 0; k < 12; k++) begin
         rst = (k == 0); fifo_full = 1'b0;
         gap = (k >= 4 && k <= 6) ? 4'b0100 : 4'b0000;
         if (k == 0) clear_all();
         if (k == 1) begin
            for (int n = 0; n < 4; n++) src_q[2].push_back({1'(n == 3), 8'(8'h50 + n)});
         end
         if (k == 3) src_q[0].push_back({1'b1, 8'h60});
         drive();
         @(negedge clk);
         n_checks++;
         if (obs !== exp_out()) begin
            n_fail++;
            $display("FAIL gap_cycle cyc=%0d got=%h required=%h", cyc, obs, exp_out());
         end
         if (gap[2]) begin
            n_checks++;
            if ({req_ready, fifo_wr_valid, grant_id, busy} !== {4'b0000, 1'b0, 2'd2, 1'b1}) begin
               n_fail++;
               $display("FAIL gap_hold cyc=%0d got ready=%b wv=%b id=%0d busy=%b required ready=0000 wv=0 id=2 busy=1",
                        cyc, req_ready, fifo_wr_valid, grant_id, busy);
            end
         end
         advance();
      end
      for (int j = 0; j < 5; j++) begin
         got = (j < dut_wr.size()) ? dut_wr[j] : -1;
         n_checks++;
         if (got !== ((j < 4) ? 2 * 256 + 'h50 + j : 'h60)) begin
            n_fail++;
            $display("FAIL gap_seq[%0d] got=%h required=%h", j, got, (j < 4) ? 2 * 256 + 'h50 + j : 'h60);
         end
      end
   endtask

   task automatic test_random();
      int len, got, want;
      for (int k = 0; k < 700; k++) begin
         rst = (k == 0);
         fifo_full = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < NUM_REQ; i++) gap[i] = ($urandom_range(0, 7) == 0);
         if (k == 0) clear_all();
         if (k > 0 && k < 650) begin
            for (int i = 0; i < NUM_REQ; i++) begin
               if (src_q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                  len = $urandom_range(1, 12);
                  for (int n = 0; n < len; n++) src_q[i].push_back({1'(n == len - 1), 8'($urandom)});
               end
            end
         end
         drive();
         @(negedge clk);
         n_checks++;
         if (obs !== exp_out()) begin
            n_fail++;
            $display("FAIL random_cycle cyc=%0d got=%h required=%h", cyc, obs, exp_out());
         end
         advance();
      end
      n_checks++;
      if (dut_wr.size() !== exp_wr.size()) begin
         n_fail++; $display("FAIL random_beat_count got=%0d required=%0d", dut_wr.size(), exp_wr.size());
      end
      for (int j = 0; j < exp_wr.size(); j++) begin
         want = exp_wr[j];
         got  = (j < dut_wr.size()) ? dut_wr[j] : -1;
         n_checks++;
         if (got !== want) begin
            n_fail++; $display("FAIL random_stream[%0d] got=%h required=%h", j, got, want);
         end
      end
   endtask

   initial begin
      n_checks = 0; n_fail = 0; cyc = 0; busy_prev = 1'b0;
      rst = 1'b1; fifo_full = 1'b0; gap = '0;
      req_valid = '0; req_last = '0; req_data = '0;
      m_owner = -1; m_gid = 0; m_ptr = NUM_REQ - 1; m_beats = 0;
      @(posedge clk);
      model_step();
      #1;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_max_burst();
      test_reset_mid();
      test_valid_gap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
